score_board: RTL and testbench
==============================

# score_board

Parametrised match scoreboard for the multi-player game top level. It counts points per player from level-style point inputs, drives a thermometer LED bar per player, and detects the match winner. It holds the result with a blinking winner bar until a new match is requested. It replaces the fixed two-player, eight-LED scorer and adds edge-detected inputs, a win condition, winner reporting and match restart.

## Interface
- NUM_PLAYERS, 2: number of players, range 2..8.
- LEDS_PER_PLAYER, 8: LED segment width per player, range 1..16.
- WIN_POINTS, 8: points that win the match, range 1..LEDS_PER_PLAYER; out-of-range values are an elaboration error.
- BLINK_CYCLES, 25_000_000: clock cycles per blink half-period, minimum 1.
- SCORE_W (localparam): $clog2(WIN_POINTS+1).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  reset, asynchronous, active-high; clock clock.
- point_in  input  NUM_PLAYERS  bit k high = player k scored; level, any length, counted once per rising edge.
- new_match  input  1  single-cycle pulse: clear scores and start a new match.
- led  output  NUM_PLAYERS*LEDS_PER_PLAYER  LED bars; segment k = bits [k*LEDS_PER_PLAYER +: LEDS_PER_PLAYER].
- score  output  NUM_PLAYERS*SCORE_W  packed per-player scores; player k at [k*SCORE_W +: SCORE_W].
- winner  output  NUM_PLAYERS  one-hot winning player, all zero while playing.
- match_over  output  1  high in WON state.

## Operation
- Reset values:
  - led = 0, score = 0, winner = 0, match_over = 0.
  - State PLAY.
  - Edge-history register = all ones, so a point_in held high through reset is not counted until it goes low and rises again.
  - Blink counter = 0, blink phase = 1.
- Edge detection: rise[k] = point_in[k] & ~prev[k]. prev samples point_in every cycle in every state.
- PLAY state:
  - For each k with rise[k] and score_k < WIN_POINTS, score_k increments by 1.
  - All players are evaluated independently in the same cycle.
- LED mapping: the segment is a thermometer of score_k.
  - Even k fills from the segment LSB upward.
  - Odd k fills from the segment MSB downward.
  - With defaults: player 0 lights bits 0..7 ascending, player 1 lights bits 15..8 starting at 15.
- Win detection:
  - If any score_k reaches WIN_POINTS on an update edge, go to WON on that same edge.
  - winner = one-hot of the lowest-index player reaching WIN_POINTS on that edge.
  - match_over = 1.
- WON state:
  - point_in is ignored; scores are frozen.
  - Non-winner segments stay static.
  - Winner segment = thermometer AND blink phase.
  - Blink counter counts 0..BLINK_CYCLES-1. At terminal count it wraps to 0 and toggles phase.
  - Counter resets to 0 and phase to 1 on entry to WON.
- new_match, accepted in any state:
  - Next edge: scores = 0, led = 0, winner = 0, match_over = 0, state PLAY.
  - new_match takes priority over any rise in the same cycle; that rise is discarded, not deferred.
- Scores never exceed WIN_POINTS and never wrap.
- reset mid-match or mid-blink returns everything to reset values immediately, independent of clock.

## Timing
- Point latency: point_in rises before edge N, so score/led update at edge N and are visible after edge N.
- Win latency: the winning point edge N also sets match_over/winner at edge N. The blink phase first toggles at edge N+BLINK_CYCLES.
- new_match latency: one edge. Outputs are cleared after the edge where new_match = 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum point_in spacing: low for at least one cycle between counted points.

## Test plan
- Reset with point_in = 2'b01 held; release reset; hold 5 cycles -> score stays 0. Drop and raise -> score0 = 1, led = 16'h0001.
- Defaults: 3 pulses on p0, 2 pulses on p1 -> score = {2,3}, led = 16'hC007, match_over = 0. A 10-cycle-wide pulse counts once.
- Simultaneous: p0 = 7 and p1 = 7, both rise same cycle -> scores 8/8 visible, winner = 2'b01, match_over = 1, further points ignored.
- BLINK_CYCLES = 4: p1 wins with p0 = 2 -> led = 16'hFF03. At +4 cycles led = 16'h0003, at +8 led = 16'hFF03; p0 bits stay static throughout.
- new_match in WON coinciding with a p0 rise -> next cycle led = 0, score = 0, winner = 0, state PLAY, the rise is not counted.
- NUM_PLAYERS = 3, LEDS_PER_PLAYER = 4, WIN_POINTS = 3: p2 scores 2 -> led = 12'h300. p1 scores 3 -> led bits [7:5] set, winner = 3'b010. Async reset asserted mid-blink -> all outputs 0 immediately.

Source files
------------

// File: rtl/score_board.sv
// score_board: per-player point counting with thermometer LED bars,
// win detection, blinking winner bar and match restart.
module score_board #(
    parameter int NUM_PLAYERS = 2,
    parameter int LEDS_PER_PLAYER = 8,
    parameter int WIN_POINTS = 8,
    parameter int BLINK_CYCLES = 25_000_000,
    localparam int SCORE_W = $clog2(WIN_POINTS + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic [NUM_PLAYERS-1:0] point_in,
    input  logic new_match,
    output logic [NUM_PLAYERS*LEDS_PER_PLAYER-1:0] led,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic [NUM_PLAYERS-1:0] winner,
    output logic match_over
);
    localparam int L = LEDS_PER_PLAYER;
    localparam int CNT_W = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;

    if (WIN_POINTS < 1 || WIN_POINTS > LEDS_PER_PLAYER || BLINK_CYCLES < 1) begin : g_bad_param
        $error("score_board: WIN_POINTS must be 1..LEDS_PER_PLAYER and BLINK_CYCLES >= 1");
    end

    typedef enum logic {PLAY, WON} state_t;
    state_t state, state_n;
    logic [NUM_PLAYERS-1:0] prev, rise, hit, winner_n;
    logic [NUM_PLAYERS*SCORE_W-1:0] score_n;
    logic [NUM_PLAYERS*L-1:0] led_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic phase, phase_n, taken, wrap;
    logic [SCORE_W-1:0] sc;

    assign match_over = state == WON;

    always_comb begin
        rise = point_in & ~prev;
        state_n = state;
        score_n = score;
        winner_n = winner;
        cnt_n = cnt;
        phase_n = phase;
        hit = '0;
        taken = 1'b0;
        sc = '0;
        led_n = '0;
        wrap = cnt == CNT_W'(BLINK_CYCLES - 1);
        if (new_match) begin
            state_n = PLAY;
            score_n = '0;
            winner_n = '0;
            cnt_n = '0;
            phase_n = 1'b1;
        end else if (state == PLAY) begin
            for (int k = 0; k < NUM_PLAYERS; k++) begin
                sc = score[k*SCORE_W +: SCORE_W];
                if (rise[k] && sc < SCORE_W'(WIN_POINTS)) begin
                    score_n[k*SCORE_W +: SCORE_W] = sc + SCORE_W'(1);
                    hit[k] = (sc + SCORE_W'(1)) == SCORE_W'(WIN_POINTS);
                end
            end
            // Simultaneous winners resolve to the lowest-index player.
            for (int k = 0; k < NUM_PLAYERS; k++) begin
                if (hit[k] && !taken) begin
                    winner_n[k] = 1'b1;
                    taken = 1'b1;
                end
            end
            if (|hit) begin
                state_n = WON;
                cnt_n = '0;
                phase_n = 1'b1;
            end
        end else begin
            cnt_n = wrap ? '0 : cnt + CNT_W'(1);
            phase_n = wrap ? ~phase : phase;
        end
        // Even players fill upward from the segment LSB, odd ones downward from the MSB.
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            sc = score_n[k*SCORE_W +: SCORE_W];
            for (int j = 0; j < L; j++) begin
                led_n[k % 2 == 1 ? k*L + L - 1 - j : k*L + j] = (j < int'(sc)) && !(winner_n[k] && !phase_n);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= PLAY;
            prev <= '1;
            score <= '0;
            winner <= '0;
            led <= '0;
            cnt <= '0;
            phase <= 1'b1;
        end else begin
            state <= state_n;
            prev <= point_in;
            score <= score_n;
            winner <= winner_n;
            led <= led_n;
            cnt <= cnt_n;
            phase <= phase_n;
        end
    end
endmodule

// File: tb/tb_score_board.sv
// tb_score_board: two configurations of score_board checked every cycle
// against a behavioural match model, plus directed literal expectations.
module tb_score_board;
    logic clock = 1'b0;
    logic reset;
    logic [1:0] point_a;
    logic [2:0] point_b;
    logic nm_a, nm_b;
    logic [15:0] led_a;
    logic [7:0] score_a;
    logic [1:0] win_a;
    logic over_a;
    logic [11:0] led_b;
    logic [5:0] score_b;
    logic [2:0] win_b;
    logic over_b;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    score_board #(.NUM_PLAYERS(2), .LEDS_PER_PLAYER(8), .WIN_POINTS(8), .BLINK_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .point_in(point_a), .new_match(nm_a),
        .led(led_a), .score(score_a), .winner(win_a), .match_over(over_a)
    );

    score_board #(.NUM_PLAYERS(3), .LEDS_PER_PLAYER(4), .WIN_POINTS(3), .BLINK_CYCLES(5)) dut_b (
        .clock(clock), .reset(reset), .point_in(point_b), .new_match(nm_b),
        .led(led_b), .score(score_b), .winner(win_b), .match_over(over_b)
    );

    int np [2] = '{2, 3};
    int lp [2] = '{8, 4};
    int wp [2] = '{8, 3};
    int bl [2] = '{4, 5};
    int sw [2] = '{4, 2};
    int sc [2][8];
    logic [7:0] prev [2];
    bit won [2];
    int wi [2];
    int since [2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(int d);
        for (int k = 0; k < 8; k++) sc[d][k] = 0;
        prev[d] = 8'hFF;
        won[d] = 0;
        wi[d] = 0;
        since[d] = 0;
    endtask

    task automatic step(int d, logic [7:0] pin, logic nm);
        if (nm) begin
            for (int k = 0; k < 8; k++) sc[d][k] = 0;
            won[d] = 0;
            since[d] = 0;
        end else if (!won[d]) begin
            for (int k = 0; k < np[d]; k++)
                if (pin[k] && !prev[d][k] && sc[d][k] < wp[d]) sc[d][k]++;
            for (int k = 0; k < np[d]; k++)
                if (!won[d] && sc[d][k] == wp[d]) begin
                    won[d] = 1;
                    wi[d] = k;
                    since[d] = 0;
                end
        end else begin
            since[d]++;
        end
        prev[d] = pin;
    endtask

    function automatic logic [31:0] m_led(int d);
        logic [31:0] v = '0;
        bit dark = won[d] && ((since[d] / bl[d]) % 2 == 1);
        for (int k = 0; k < np[d]; k++)
            for (int j = 0; j < lp[d]; j++)
                if (j < sc[d][k] && !(dark && wi[d] == k))
                    v[k*lp[d] + ((k % 2 == 1) ? lp[d] - 1 - j : j)] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] m_score(int d);
        logic [31:0] v = '0;
        for (int k = 0; k < np[d]; k++) v |= 32'(sc[d][k]) << (k * sw[d]);
        return v;
    endfunction

    function automatic logic [31:0] m_win(int d);
        return won[d] ? 32'(1) << wi[d] : 32'(0);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            step(0, {6'd0, point_a}, nm_a);
            step(1, {5'd0, point_b}, nm_b);
        end
    end

    always @(negedge clock) begin
        chk("a_led", 32'(led_a), m_led(0));
        chk("a_score", 32'(score_a), m_score(0));
        chk("a_winner", 32'(win_a), m_win(0));
        chk("a_match_over", 32'(over_a), 32'(won[0]));
        chk("b_led", 32'(led_b), m_led(1));
        chk("b_score", 32'(score_b), m_score(1));
        chk("b_winner", 32'(win_b), m_win(1));
        chk("b_match_over", 32'(over_b), 32'(won[1]));
    end

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_a(logic [1:0] m, int w);
        point_a = m;
        tick(w);
        point_a = '0;
        tick(1);
    endtask

    task automatic pulse_b(logic [2:0] m);
        point_b = m;
        tick(1);
        point_b = '0;
        tick(1);
    endtask

    initial begin
        reset = 1'b1;
        point_a = 2'b01;
        point_b = '0;
        nm_a = 1'b0;
        nm_b = 1'b0;
        tick(3);
        chk("lit_reset_led", 32'(led_a), 32'h0);
        reset = 1'b0;
        tick(5);
        chk("lit_held_through_reset", 32'(score_a), 32'h0);
        point_a = 2'b00;
        tick(1);
        point_a = 2'b01;
        tick(1);
        chk("lit_first_point_score", 32'(score_a), 32'h01);
        chk("lit_first_point_led", 32'(led_a), 32'h0001);
        point_a = 2'b00;
        tick(1);
        pulse_a(2'b01, 10);
        pulse_a(2'b01, 1);
        pulse_a(2'b10, 1);
        pulse_a(2'b10, 1);
        chk("lit_score_32", 32'(score_a), 32'h23);
        chk("lit_led_c007", 32'(led_a), 32'hC007);
        chk("lit_not_over", 32'(over_a), 32'h0);
        nm_a = 1'b1;
        tick(1);
        nm_a = 1'b0;
        chk("lit_new_match_clear", 32'(score_a), 32'h0);
        repeat (7) pulse_a(2'b11, 1);
        point_a = 2'b11;
        tick(1);
        chk("lit_tie_score", 32'(score_a), 32'h88);
        chk("lit_tie_winner", 32'(win_a), 32'h1);
        chk("lit_tie_over", 32'(over_a), 32'h1);
        point_a = 2'b00;
        tick(1);
        pulse_a(2'b10, 1);
        chk("lit_frozen_score", 32'(score_a), 32'h88);
        nm_a = 1'b1;
        tick(1);
        nm_a = 1'b0;
        pulse_a(2'b01, 1);
        pulse_a(2'b01, 1);
        repeat (7) pulse_a(2'b10, 1);
        point_a = 2'b10;
        tick(1);
        chk("lit_win_led_ff03", 32'(led_a), 32'hFF03);
        chk("lit_win_p1", 32'(win_a), 32'h2);
        point_a = 2'b00;
        tick(4);
        chk("lit_blink_off_0003", 32'(led_a), 32'h0003);
        tick(4);
        chk("lit_blink_on_ff03", 32'(led_a), 32'hFF03);
        nm_a = 1'b1;
        point_a = 2'b01;
        tick(1);
        nm_a = 1'b0;
        chk("lit_nm_led", 32'(led_a), 32'h0);
        chk("lit_nm_score", 32'(score_a), 32'h0);
        chk("lit_nm_winner", 32'(win_a), 32'h0);
        chk("lit_nm_over", 32'(over_a), 32'h0);
        tick(2);
        chk("lit_nm_rise_discarded", 32'(score_a), 32'h0);
        point_a = 2'b00;
        tick(1);
        pulse_b(3'b100);
        pulse_b(3'b100);
        chk("lit_b_led_300", 32'(led_b), 32'h300);
        pulse_b(3'b010);
        pulse_b(3'b010);
        point_b = 3'b010;
        tick(1);
        chk("lit_b_led_3e0", 32'(led_b), 32'h3E0);
        chk("lit_b_winner", 32'(win_b), 32'h2);
        point_b = '0;
        tick(7);
        chk("lit_b_blink_off", 32'(led_b), 32'h300);
        #2 reset = 1'b1;
        #1;
        chk("lit_async_led_a", 32'(led_a), 32'h0);
        chk("lit_async_led_b", 32'(led_b), 32'h0);
        chk("lit_async_score_b", 32'(score_b), 32'h0);
        chk("lit_async_winner_b", 32'(win_b), 32'h0);
        chk("lit_async_over_b", 32'(over_b), 32'h0);
        tick(1);
        reset = 1'b0;
        repeat (3000) begin
            point_a = 2'($urandom);
            point_b = 3'($urandom);
            nm_a = $urandom_range(0, 39) == 0;
            nm_b = $urandom_range(0, 39) == 0;
            tick(1);
        end
        point_a = '0;
        point_b = '0;
        nm_a = 1'b0;
        nm_b = 1'b0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
